alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Microsequencer that runs a short stored program on the shared ALU: it fetches instructions from a synchronous program memory, reads operands from an internal register file, drives the external ALU, and writes results and flags back. It sits between the host (register load/readback, start/done handshake) and the ALU instance. It executes one instruction every 3 cycles until a HALT instruction or the end of the program.

## Interface
- `WIDTH`, 8: data width; matches the ALU `WIDTH` parameter.
- `PROG_DEPTH`, 16: program memory depth; power of two, max 256.
- `NREGS`, 8: register file entries; fixed at 8 (3-bit register fields).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset; synchronous and active-low.
- `start` input 1: begin a program at address 0; sampled only in IDLE.
- `busy` output 1: high from FETCH through EXEC.
- `done` output 1: one-cycle pulse at program end.
- `prog_addr` output log2(PROG_DEPTH): program memory address (registered PC).
- `prog_data` input 13: instruction word, valid one cycle after `prog_addr`.
- `host_we` input 1: register write strobe; honoured only when not busy.
- `host_waddr` input 3: write register index.
- `host_wdata` input WIDTH: write data.
- `host_raddr` input 3: read register index.
- `host_rdata` output WIDTH: combinational read of `reg[host_raddr]`.
- `alu_a`, `alu_b` output WIDTH: ALU operands.
- `alu_op` output 3: ALU opcode.
- `alu_y` input WIDTH: ALU result.
- `alu_c` input 1: ALU carry.
- `alu_zero` input 1: ALU zero flag.
- `carry_flag`, `zero_flag` output 1: registered flags from the last executed instruction.
- `instr_count` output 8: count of instructions executed in the current or last run; wraps at 255.

## Operation
- Instruction word fields:
  - [12] halt
  - [11:9] opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT, 101 XOR, 110 SLL, 111 SRL
  - [8:6] rd
  - [5:3] ra
  - [2:0] rb
- FSM states: IDLE, FETCH, DECODE, EXEC, DONE.
- IDLE: when `start`=1, clear PC, `instr_count`, and both flags, then go to FETCH.
- FETCH: `prog_addr` = PC; memory read is in flight.
- DECODE: latch `prog_data` into the instruction register.
  - halt=1: go to DONE. The HALT word is not counted.
  - halt=0: go to EXEC.
- EXEC: drive `alu_a` = reg[ra], `alu_b` = reg[rb], `alu_op` = opcode. On the closing edge:
  - reg[rd] ← `alu_y`; `carry_flag` ← `alu_c`; `zero_flag` ← `alu_zero`; `instr_count`++.
  - If PC = PROG_DEPTH−1, go to DONE (no wrap). Otherwise PC++ and go to FETCH.
- DONE: `done`=1 for one cycle, then IDLE.
- Outside EXEC, `alu_a`, `alu_b` and `alu_op` are driven to 0.
- rd may equal ra and/or rb. The read happens in EXEC, the write on the closing edge, so the old value is used.
- Sequencer does not interpret carry semantics (ADD carry-out, SUB borrow); it latches `alu_c` verbatim.
- `start` outside IDLE is ignored. `host_we` while `busy`=1 or in DONE is ignored.
- Reset (`rst_n`=0 at a clock edge), including mid-program:
  - state → IDLE; PC, flags, `instr_count`, all registers, and `done` → 0.
  - `busy`=0; `prog_addr`=0.

## Timing
- Start accepted at edge 0; FETCH occupies cycle 1.
- Program ending in HALT after N executed instructions: `done` high in cycle 3N+3.
- Program running off the end with no HALT (N = PROG_DEPTH): `done` high in cycle 3N+1.
- `busy` falls in the DONE cycle. The earliest next start is sampled in the following IDLE cycle.
- Register write and flag update become visible on `host_rdata` and flag outputs the cycle after EXEC.

## Structure
- Shared package holds:
  - opcode localparams (`OP_ADD` … `OP_SRL`), shared with the ALU;
  - instruction field bit positions;
  - the FSM state enum.
- Sub-module `seq_regfile`: 8×WIDTH register file with one synchronous write port, two combinational read ports plus the host read port, and synchronous active-low clear.
- The ALU stays outside; the top level wires it to the `alu_*` ports.

## Test plan
- **ADD with carry:** preload r1=254, r2=6; program [ADD r3,r1,r2; HALT]. Expect r3=4, `carry_flag`=1, `zero_flag`=0, `instr_count`=1, `done` in cycle 6.
- **Zero result:** r1=10, r2=5; program [AND r4,r1,r2; XOR r5,r1,r1; HALT]. Expect r4=0 then r5=0, `zero_flag`=1, `done` in cycle 9.
- **Self-overwrite and shifts:** r1=11, r2=2; program [SLL r1,r1,r2; SRL r6,r1,r2; HALT]. Expect r1=44, r6=11.
- **Run off the end:** PROG_DEPTH=16 with all entries `OR r0,r0,r0`, no HALT. Expect `done` in cycle 49, `instr_count`=16, `prog_addr` never wraps past 15.
- **Ignored inputs while busy:** assert `start` and `host_we` (r1←99) during EXEC. Expect no restart, r1 unchanged, a single `done` pulse.
- **Reset mid-program:** drop `rst_n` during DECODE of instruction 2. Expect IDLE, all registers 0, `busy`=0, and no `done` pulse.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU microsequencer: opcodes, instruction field
// layout and the sequencer state encoding.
package alu_op_sequencer_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    localparam int unsigned INSTR_W  = 13;
    localparam int unsigned BODY_W   = 12;
    localparam int unsigned HALT_BIT = 12;
    localparam int unsigned OPC_LSB  = 9;
    localparam int unsigned RD_LSB   = 6;
    localparam int unsigned RA_LSB   = 3;
    localparam int unsigned RB_LSB   = 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_DONE   = 3'd4
    } seq_state_e;

    // The halt bit is consumed at decode, so the instruction register keeps only the body.
    function automatic logic [2:0] field3(input logic [BODY_W-1:0] body, input int unsigned lsb);
        return body[lsb +: 3];
    endfunction

endpackage

// File: rtl/alu_op_sequencer_regfile.sv
// 8-entry register file: one synchronous write port, two operand read ports
// and a host read port, all reads combinational; synchronous active-low clear.
module seq_regfile #(
    parameter int WIDTH = 8,
    parameter int NREGS = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             we_i,
    input  logic [2:0]       waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [2:0]       raddr_a_i,
    input  logic [2:0]       raddr_b_i,
    input  logic [2:0]       raddr_h_i,
    output logic [WIDTH-1:0] rdata_a_o,
    output logic [WIDTH-1:0] rdata_b_o,
    output logic [WIDTH-1:0] rdata_h_o
);

    logic [WIDTH-1:0] mem_q [NREGS];

    // Register storage with synchronous clear
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];
    assign rdata_h_o = mem_q[raddr_h_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// Microsequencer: fetches a stored program, drives the external ALU and writes
// results and flags back, one instruction every three cycles.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PROG_DEPTH = 16,
    parameter int NREGS      = 8,
    localparam int AW        = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               host_we,
    input  logic [2:0]         host_waddr,
    input  logic [WIDTH-1:0]   host_wdata,
    input  logic [2:0]         host_raddr,
    output logic [WIDTH-1:0]   host_rdata,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         alu_op,
    input  logic [WIDTH-1:0]   alu_y,
    input  logic               alu_c,
    input  logic               alu_zero,
    output logic               carry_flag,
    output logic               zero_flag,
    output logic [7:0]         instr_count
);

    localparam logic [AW-1:0] PC_LAST = AW'(PROG_DEPTH - 1);

    seq_state_e        state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [BODY_W-1:0] ir_q, ir_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              rf_we_s;
    logic [2:0]        rf_waddr_s;
    logic [WIDTH-1:0]  rf_wdata_s;
    logic [WIDTH-1:0]  rd_a_s, rd_b_s;
    logic [2:0]        opc_s, rd_s, ra_s, rb_s;
    logic              exec_s;

    assign opc_s  = field3(ir_q, OPC_LSB);
    assign rd_s   = field3(ir_q, RD_LSB);
    assign ra_s   = field3(ir_q, RA_LSB);
    assign rb_s   = field3(ir_q, RB_LSB);
    assign exec_s = (state_q == S_EXEC);

    seq_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk       (clk),
        .clr_n     (rst_n),
        .we_i      (rf_we_s),
        .waddr_i   (rf_waddr_s),
        .wdata_i   (rf_wdata_s),
        .raddr_a_i (ra_s),
        .raddr_b_i (rb_s),
        .raddr_h_i (host_raddr),
        .rdata_a_o (rd_a_s),
        .rdata_b_o (rd_b_s),
        .rdata_h_o (host_rdata)
    );

    // Next-state, datapath update and register-file write selection
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        cnt_d      = cnt_q;
        rf_we_s    = 1'b0;
        rf_waddr_s = host_waddr;
        rf_wdata_s = host_wdata;
        case (state_q)
            S_IDLE: begin
                rf_we_s = host_we;
                if (start) begin
                    pc_d    = '0;
                    cnt_d   = 8'd0;
                    carry_d = 1'b0;
                    zero_d  = 1'b0;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d = prog_data[BODY_W-1:0];
                if (prog_data[HALT_BIT]) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Operands were read this cycle, so rd==ra/rb sees the old value.
                rf_we_s    = 1'b1;
                rf_waddr_s = rd_s;
                rf_wdata_s = alu_y;
                carry_d    = alu_c;
                zero_d     = alu_zero;
                cnt_d      = cnt_q + 8'd1;
                if (pc_q == PC_LAST) begin
                    state_d = S_DONE;
                end else begin
                    pc_d    = pc_q + {{(AW-1){1'b0}}, 1'b1};
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy        = (state_q == S_FETCH) || (state_q == S_DECODE) || exec_s;
    assign done        = (state_q == S_DONE);
    assign prog_addr   = pc_q;
    assign carry_flag  = carry_q;
    assign zero_flag   = zero_q;
    assign instr_count = cnt_q;
    assign alu_a       = exec_s ? rd_a_s : '0;
    assign alu_b       = exec_s ? rd_b_s : '0;
    assign alu_op      = exec_s ? opc_s : 3'b000;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU and program ROM.
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done;
    logic [3:0]  prog_addr;
    logic [12:0] prog_data;
    logic        host_we = 1'b0;
    logic [2:0]  host_waddr = 3'd0;
    logic [7:0]  host_wdata = 8'd0;
    logic [2:0]  host_raddr = 3'd0;
    logic [7:0]  host_rdata;
    logic [7:0]  alu_a, alu_b, alu_y;
    logic [2:0]  alu_op;
    logic        alu_c, alu_zero;
    logic        carry_flag, zero_flag;
    logic [7:0]  instr_count;

    logic [12:0] prog [16];
    logic [8:0]  alu_full;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cyc, pulses;
    logic busy_c1, busy_dn;
    logic [3:0] addr_dn, max_addr;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(8), .PROG_DEPTH(16), .NREGS(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
        .host_raddr(host_raddr), .host_rdata(host_rdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_c(alu_c), .alu_zero(alu_zero),
        .carry_flag(carry_flag), .zero_flag(zero_flag), .instr_count(instr_count)
    );

    // Synchronous program memory
    always_ff @(posedge clk) prog_data <= prog[prog_addr];

    // Behavioural ALU
    always_comb begin
        alu_full = 9'd0;
        case (alu_op)
            OP_ADD:  alu_full = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB:  alu_full = {1'b0, alu_a} - {1'b0, alu_b};
            OP_AND:  alu_full = {1'b0, alu_a & alu_b};
            OP_OR:   alu_full = {1'b0, alu_a | alu_b};
            OP_NOT:  alu_full = {1'b0, ~alu_a};
            OP_XOR:  alu_full = {1'b0, alu_a ^ alu_b};
            OP_SLL:  alu_full = {1'b0, alu_a << alu_b};
            OP_SRL:  alu_full = {1'b0, alu_a >> alu_b};
            default: alu_full = 9'd0;
        endcase
    end
    assign alu_y    = alu_full[7:0];
    assign alu_c    = alu_full[8];
    assign alu_zero = (alu_full[7:0] == 8'd0);

    function automatic logic [12:0] ins(input logic h, input logic [2:0] op,
                                        input logic [2:0] rd, input logic [2:0] ra,
                                        input logic [2:0] rb);
        return {h, op, rd, ra, rb};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic host_write(input int idx, input int val);
        @(negedge clk);
        host_we    = 1'b1;
        host_waddr = 3'(idx);
        host_wdata = 8'(val);
        @(negedge clk);
        host_we    = 1'b0;
    endtask

    task automatic check_reg(input string tag, input int idx, input int exp);
        host_raddr = 3'(idx);
        #1;
        check(tag, {24'd0, host_rdata}, exp);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 13'h1000;
    endtask

    // Start a run and observe it for max_cyc cycles; inj_cyc pokes start/host_we, rst_cyc drops rst_n
    task automatic run_prog(input int max_cyc, input int inj_cyc, input int rst_cyc);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        done_cyc = 0;
        pulses   = 0;
        busy_c1  = busy;
        busy_dn  = 1'b1;
        addr_dn  = 4'd0;
        max_addr = 4'd0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            if (prog_addr > max_addr) max_addr = prog_addr;
            if (done) begin
                pulses++;
                if (done_cyc == 0) begin
                    done_cyc = cyc;
                    busy_dn  = busy;
                    addr_dn  = prog_addr;
                end
            end
            start      = (cyc == inj_cyc);
            host_we    = (cyc == inj_cyc);
            host_waddr = 3'd1;
            host_wdata = 8'd99;
            rst_n      = !(cyc == rst_cyc);
            @(posedge clk);
            #1;
        end
        start   = 1'b0;
        host_we = 1'b0;
        rst_n   = 1'b1;
    endtask

    initial begin
        clear_prog();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", prog_addr, 0);
        check("rst_cnt", instr_count, 0);
        check("rst_carry", carry_flag, 0);
        check("rst_alu_op", alu_op, 0);
        check_reg("rst_r0", 0, 0);

        // ADD with carry
        host_write(1, 254);
        host_write(2, 6);
        clear_prog();
        prog[0] = ins(1'b0, OP_ADD, 3'd3, 3'd1, 3'd2);
        run_prog(12, 0, 0);
        check("add_done_cyc", done_cyc, 6);
        check("add_pulses", pulses, 1);
        check("add_busy_c1", busy_c1, 1);
        check("add_busy_done", busy_dn, 0);
        check_reg("add_r3", 3, 4);
        check("add_carry", carry_flag, 1);
        check("add_zero", zero_flag, 0);
        check("add_cnt", instr_count, 1);

        // Zero result
        host_write(1, 10);
        host_write(2, 5);
        host_write(4, 77);
        host_write(5, 88);
        clear_prog();
        prog[0] = ins(1'b0, OP_AND, 3'd4, 3'd1, 3'd2);
        prog[1] = ins(1'b0, OP_XOR, 3'd5, 3'd1, 3'd1);
        run_prog(14, 0, 0);
        check("zero_done_cyc", done_cyc, 9);
        check_reg("zero_r4", 4, 0);
        check_reg("zero_r5", 5, 0);
        check("zero_flag", zero_flag, 1);
        check("zero_carry", carry_flag, 0);
        check("zero_cnt", instr_count, 2);

        // Self-overwrite and shifts
        host_write(1, 11);
        host_write(2, 2);
        host_write(6, 200);
        clear_prog();
        prog[0] = ins(1'b0, OP_SLL, 3'd1, 3'd1, 3'd2);
        prog[1] = ins(1'b0, OP_SRL, 3'd6, 3'd1, 3'd2);
        run_prog(14, 0, 0);
        check("shift_done_cyc", done_cyc, 9);
        check_reg("shift_r1", 1, 44);
        check_reg("shift_r6", 6, 11);
        check("shift_zero", zero_flag, 0);

        // Run off the end of the program
        host_write(0, 5);
        for (int i = 0; i < 16; i++) prog[i] = ins(1'b0, OP_OR, 3'd0, 3'd0, 3'd0);
        run_prog(60, 0, 0);
        check("end_done_cyc", done_cyc, 49);
        check("end_pulses", pulses, 1);
        check("end_cnt", instr_count, 16);
        check("end_addr_done", addr_dn, 15);
        check("end_max_addr", max_addr, 15);
        check_reg("end_r0", 0, 5);

        // start and host_we ignored during EXEC
        host_write(1, 5);
        host_write(2, 3);
        clear_prog();
        prog[0] = ins(1'b0, OP_ADD, 3'd3, 3'd1, 3'd2);
        run_prog(16, 3, 0);
        check("busy_done_cyc", done_cyc, 6);
        check("busy_pulses", pulses, 1);
        check_reg("busy_r1", 1, 5);
        check_reg("busy_r3", 3, 8);
        check("busy_cnt", instr_count, 1);

        // Reset during DECODE of the second instruction
        host_write(1, 200);
        host_write(2, 100);
        clear_prog();
        prog[0] = ins(1'b0, OP_ADD, 3'd3, 3'd1, 3'd2);
        prog[1] = ins(1'b0, OP_ADD, 3'd4, 3'd3, 3'd2);
        run_prog(20, 0, 5);
        check("rstm_pulses", pulses, 0);
        check("rstm_busy", busy, 0);
        check("rstm_addr", prog_addr, 0);
        check("rstm_cnt", instr_count, 0);
        check("rstm_carry", carry_flag, 0);
        for (int r = 0; r < 8; r++) check_reg("rstm_reg", r, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
